// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared constants for the 5-stage CPU pipeline registers: architectural
//   widths, EX/MEM control-bit positions and per-stage payload widths.
//   A small typed view of the EX/MEM control bits and a packing helper are
//   provided so stage logic does not hard-code bit positions.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;

  // EX/MEM control bits
  localparam int EX_MEM_CTRL_W = 4;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;

  // Per-stage data payload widths
  localparam int IF_ID_DATA_W  = 2 * XLEN;                    // pc + instr
  localparam int ID_EX_DATA_W  = 4 * XLEN + 3 * REG_ADDR_W;   // pc, rs1/rs2 vals, imm, rs1/rs2/rd
  localparam int EX_MEM_DATA_W = 2 * XLEN + REG_ADDR_W;       // alu_out + rs2 + rd = 69
  localparam int MEM_WB_DATA_W = 2 * XLEN + REG_ADDR_W;       // mem_data + alu_out + rd

  // First member is the MSB, so regwrite lands on bit 0.
  typedef struct packed {
    logic memwrite;
    logic memread;
    logic memtoreg;
    logic regwrite;
  } ex_mem_ctrl_t;

  function automatic logic [EX_MEM_CTRL_W-1:0] pack_ex_mem_ctrl(
    input logic regwrite,
    input logic memtoreg,
    input logic memread,
    input logic memwrite
  );
    logic [EX_MEM_CTRL_W-1:0] c;
    c                = '0;
    c[CTRL_REGWRITE] = regwrite;
    c[CTRL_MEMTOREG] = memtoreg;
    c[CTRL_MEMREAD]  = memread;
    c[CTRL_MEMWRITE] = memwrite;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
//   One-entry skid buffer sitting in front of the stage output register.
//   ready_o is a flop, so there is no combinational path from the downstream
//   ready back to the upstream ready. A beat that arrives while the output
//   register is holding is parked here; on the next output load the parked
//   beat is handed over before any new upstream beat.
//   Used only when PIPE_SKID_BUF_EN is defined.
// Ports
//   clk_i, rst_i       clock, synchronous active-low reset
//   flush_i            empty the entry, re-open ready
//   valid_i/ctrl_i/data_i  upstream beat
//   out_load_i         output register loads this edge (!valid_o || ready_i)
//   ready_o            registered: entry is empty
//   skid_valid_o/ctrl_o/data_o  parked beat
// ---------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int DATA_W = EX_MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              out_load_i,
  output logic              ready_o,
  output logic              skid_valid_o,
  output logic [CTRL_W-1:0] skid_ctrl_o,
  output logic [DATA_W-1:0] skid_data_o
);

  logic              skid_valid_d, skid_valid_q;
  logic [CTRL_W-1:0] skid_ctrl_d,  skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_d,  skid_data_q;
  logic              ready_d,      ready_q;
  logic              accept;

  assign accept = valid_i && ready_q;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (out_load_i) begin
      // Either the parked beat moves to the output now, or the entry was
      // empty and the upstream beat bypasses straight to the output.
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = ctrl_i;
      skid_data_d  = data_i;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign ready_o      = ready_q;
  assign skid_valid_o = skid_valid_q;
  assign skid_ctrl_o  = skid_ctrl_q;
  assign skid_data_o  = skid_data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage pipeline register with valid/ready handshake, flush
//   (bubble insertion), saturating back-pressure counter and an optional
//   skid buffer. Control bits are forced to zero on every bubble; data bits
//   are held and are don't-care while valid_o is low.
//   Build option: define PIPE_SKID_BUF_EN to register ready_o through a
//   one-entry skid buffer; otherwise ready_o = !valid_o || ready_i.
// Ports
//   clk_i, rst_i        clock, synchronous active-low reset
//   valid_i, ready_o    upstream handshake
//   ctrl_i, data_i      upstream payload
//   flush_i             kill stage contents
//   valid_o, ready_i    downstream handshake
//   ctrl_o, data_o      registered payload (ctrl_o zero when !valid_o)
//   stall_cnt_o         saturating count of cycles with valid_o && !ready_i
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = EX_MEM_CTRL_W,
  parameter int DATA_W   = EX_MEM_DATA_W,
  parameter int STALL_CW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [CTRL_W-1:0]   ctrl_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                flush_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [STALL_CW-1:0] stall_cnt_o
);

  logic                valid_d,     valid_q;
  logic [CTRL_W-1:0]   ctrl_d,      ctrl_q;
  logic [DATA_W-1:0]   data_d,      data_q;
  logic [STALL_CW-1:0] stall_cnt_d, stall_cnt_q;

  logic                out_load;
  logic                src_valid;
  logic [CTRL_W-1:0]   src_ctrl;
  logic [DATA_W-1:0]   src_data;

  // Output register may take a new value when empty or when its beat leaves.
  assign out_load = !valid_q || ready_i;

`ifdef PIPE_SKID_BUF_EN
  logic              skid_ready;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ctrl_i       (ctrl_i),
    .data_i       (data_i),
    .out_load_i   (out_load),
    .ready_o      (skid_ready),
    .skid_valid_o (skid_valid),
    .skid_ctrl_o  (skid_ctrl),
    .skid_data_o  (skid_data)
  );

  // A parked beat is older than anything upstream, so it always goes first.
  // While it is parked ready_o is low, so no upstream beat is lost.
  assign src_valid = skid_valid ? 1'b1      : valid_i;
  assign src_ctrl  = skid_valid ? skid_ctrl : ctrl_i;
  assign src_data  = skid_valid ? skid_data : data_i;
  assign ready_o   = skid_ready;
`else
  assign src_valid = valid_i;
  assign src_ctrl  = ctrl_i;
  assign src_data  = data_i;
  assign ready_o   = out_load;
`endif

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    stall_cnt_d = stall_cnt_q;

    // Counter looks only at the current handshake state; flush does not
    // touch it.
    if (valid_q && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CW'(1);
    end

    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (out_load) begin
      valid_d = src_valid;
      if (src_valid) begin
        ctrl_d = src_ctrl;
        data_d = src_data;
      end else begin
        // Bubble: control cleared, data left as it was.
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_o     = valid_q;
  assign ctrl_o      = ctrl_q;
  assign data_o      = data_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 69;
  localparam int SW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [SW-1:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(
    .CTRL_W   (CW),
    .DATA_W   (DW),
    .STALL_CW (SW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  int total = 0;
  int bad   = 0;
  logic [CW+DW-1:0] exp_q[$];
  logic [CW+DW-1:0] mon_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat leaving the stage must match the head of the queue.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (!valid_o) check("ctrl_zero_when_invalid", 128'(ctrl_o), 128'(0));
      if (valid_o && ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want no beat (t=%0t)", {ctrl_o, data_o}, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_beat", 128'({ctrl_o, data_o}), 128'(mon_exp));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    step();
    rst_i = 1'b1;
  endtask

  // Offer a beat until accepted; returns cycles taken.
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit push, output int waited);
    bit acc;
    acc     = 1'b0;
    waited  = 0;
    valid_i = 1'b1;
    ctrl_i  = c;
    data_i  = d;
    if (push) exp_q.push_back({c, d});
    while (!acc && waited < 50) begin
      @(negedge clk_i);
      acc = ready_o;
      step();
      waited++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept for data %0h", d);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;

    // T1 reset with an upstream beat present
    rst_i   = 1'b0;
    valid_i = 1'b1;
    ctrl_i  = 4'hF;
    data_i  = 69'h1234;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_ctrl", 128'(ctrl_o), 128'(0));
    check("rst_data", 128'(data_o), 128'(0));
    check("rst_cnt", 128'(stall_cnt_o), 128'(0));
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ctrl_i  = '0;
    data_i  = '0;
    #1;
    check("rst_ready", 128'(ready_o), 128'(1));

    // T2 back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      send(4'(i), 69'(i), 1'b1, w);
      check("stream_wait", 128'(w), 128'(1));
      check("stream_valid", 128'(valid_o), 128'(1));
      check("stream_data", 128'(data_o), 128'(i));
    end
    step();
    check("stream_end_valid", 128'(valid_o), 128'(0));
    check("stream_cnt", 128'(stall_cnt_o), 128'(0));

    // T3 stall, then second beat while holding
    do_reset();
    ready_i = 1'b0;
    send(4'b1001, 69'hAB, 1'b1, w);
    check("stall_load_data", 128'(data_o), 128'hAB);
    check("stall_load_cnt", 128'(stall_cnt_o), 128'(0));
    repeat (5) step();
    check("stall_cnt5", 128'(stall_cnt_o), 128'(5));
    check("stall_hold_data", 128'(data_o), 128'hAB);
    check("stall_hold_ctrl", 128'(ctrl_o), 128'b1001);
    check("stall_hold_valid", 128'(valid_o), 128'(1));
    valid_i = 1'b1;
    ctrl_i  = 4'h6;
    data_i  = 69'hCD;
    exp_q.push_back({4'h6, 69'hCD});
    step();
    check("skid_cnt6", 128'(stall_cnt_o), 128'(6));
    check("skid_ready_low", 128'(ready_o), 128'(0));
    check("skid_out_still_ab", 128'(data_o), 128'hAB);
`ifdef PIPE_SKID_BUF_EN
    valid_i = 1'b0;
`endif
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("release_data_cd", 128'(data_o), 128'hCD);
    check("release_ctrl", 128'(ctrl_o), 128'h6);
    check("release_valid", 128'(valid_o), 128'(1));
    step();
    check("release_bubble", 128'(valid_o), 128'(0));
    check("release_cnt", 128'(stall_cnt_o), 128'(6));

    // T4 flush with full stage (and skid full when present)
    do_reset();
    ready_i = 1'b0;
    send(4'hF, 69'h111, 1'b0, w);
    valid_i = 1'b1;
    ctrl_i  = 4'hF;
    data_i  = 69'h222;
    step();
    check("flush_pre_ready", 128'(ready_o), 128'(0));
    data_i  = 69'h333;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_valid", 128'(valid_o), 128'(0));
    check("flush_ctrl", 128'(ctrl_o), 128'(0));
    #1;
    check("flush_ready", 128'(ready_o), 128'(1));
    ready_i = 1'b1;
    repeat (3) step();
    check("flush_no_leak", 128'(valid_o), 128'(0));
    // flush with an empty stage: the incoming beat is accepted then dropped
    valid_i = 1'b1;
    ctrl_i  = 4'hF;
    data_i  = 69'h444;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_drop_in", 128'(valid_o), 128'(0));

    // T5 bubble after a beat
    send(4'hF, 69'h5A5, 1'b1, w);
    check("bubble_pre_ctrl", 128'(ctrl_o), 128'hF);
    step();
    check("bubble_valid", 128'(valid_o), 128'(0));
    check("bubble_ctrl", 128'(ctrl_o), 128'(0));
    check("bubble_data_held", 128'(data_o), 128'h5A5);

    // T6 counter saturation (3-bit counter)
    do_reset();
    ready_i = 1'b0;
    send(4'h2, 69'h77, 1'b1, w);
    repeat (7) step();
    check("sat_cnt7", 128'(stall_cnt_o), 128'(7));
    repeat (3) step();
    check("sat_cnt_hold", 128'(stall_cnt_o), 128'(7));
    check("sat_data", 128'(data_o), 128'h77);
    ready_i = 1'b1;
    step();
    check("sat_drain_valid", 128'(valid_o), 128'(0));
    check("sat_cnt_after", 128'(stall_cnt_o), 128'(7));

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
